// File: rtl/riscv_opimm_exec.sv
// Multicycle execute unit for the RISC-V OP-IMM group with a private XLEN-wide register file.
// Latency: 4 edges from accept to register write (IDLE->DECODE->EXEC->WB), done pulses in WB.
// Backpressure: in_ready only in IDLE; a new instruction is taken 4 edges after the previous one.
module riscv_opimm_exec #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            done,
  output logic            illegal,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            dbg_we,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic [XLEN-1:0] dbg_rdata
);

  localparam int SHW = (XLEN == 64) ? 6 : 5;
  // Bits of instr[31:20] that lie above the shift amount and must be zero for shifts.
  localparam logic [11:0] SH_UPPER = 12'hfff << SHW;
  // instr[30] (bit 10 of the immediate) selects srl/sra and is allowed for funct3=101.
  localparam logic [11:0] SRA_SEL = 12'h400;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  state_t            state_q, state_d;
  logic [31:0]       instr_q;
  logic [XLEN-1:0]   rs1_q, imm_q, res_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              ill_q;
  logic [XLEN-1:0]   regs_q [NREGS];

  logic [6:0]        dec_opc;
  logic [2:0]        dec_f3;
  logic [4:0]        dec_rs1, dec_rd;
  logic [11:0]       dec_hi12;
  logic              dec_ill;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   alu;
  logic [SHW-1:0]    shamt;
  logic              wb_we, dbg_ok;

  assign dec_opc  = instr_q[6:0];
  assign dec_rd   = instr_q[11:7];
  assign dec_f3   = instr_q[14:12];
  assign dec_rs1  = instr_q[19:15];
  assign dec_hi12 = instr_q[31:20];
  assign shamt    = imm_q[SHW-1:0];
  assign wb_we    = (state_q == S_WB) && !ill_q && (rd_q != 5'd0);
  assign dbg_ok   = (state_q == S_IDLE) && dbg_we && (dbg_addr != 5'd0) &&
                    ({1'b0, dbg_addr} < 6'(NREGS));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: fixed four-step walk, leaving IDLE only on a handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are pure functions of state; wb fields read zero outside WB
  always_comb begin
    in_ready = (state_q == S_IDLE);
    done     = (state_q == S_WB);
    illegal  = (state_q == S_WB) && ill_q;
    wb_rd    = (state_q == S_WB) ? rd_q : 5'd0;
    wb_data  = ((state_q == S_WB) && !ill_q) ? res_q : '0;
  end

  // Legality of the latched word: opcode, shift funct bits and register indices
  always_comb begin
    dec_ill = (dec_opc != 7'b0010011) ||
              ({1'b0, dec_rs1} >= 6'(NREGS)) ||
              ({1'b0, dec_rd}  >= 6'(NREGS));
    if (dec_f3 == 3'b001 && (dec_hi12 & SH_UPPER) != 12'd0)
      dec_ill = 1'b1;
    if (dec_f3 == 3'b101 && (dec_hi12 & SH_UPPER & ~SRA_SEL) != 12'd0)
      dec_ill = 1'b1;
  end

  // Register file read ports: rs1 for DECODE, and the debug port; x0 and out-of-range read 0
  always_comb begin
    rs1_val   = '0;
    dbg_rdata = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (dec_rs1 == 5'(i))  rs1_val   = regs_q[i];
      if (dbg_addr == 5'(i)) dbg_rdata = regs_q[i];
    end
  end

  // ALU on the decoded operands; the immediate already carries shamt and the sra select
  always_comb begin
    alu = '0;
    case (f3_q)
      3'b000: alu = rs1_q + imm_q;
      3'b010: alu = {{(XLEN-1){1'b0}}, ($signed(rs1_q) < $signed(imm_q))};
      3'b011: alu = {{(XLEN-1){1'b0}}, (rs1_q < imm_q)};
      3'b100: alu = rs1_q ^ imm_q;
      3'b110: alu = rs1_q | imm_q;
      3'b111: alu = rs1_q & imm_q;
      3'b001: alu = rs1_q << shamt;
      3'b101: alu = imm_q[10] ? XLEN'($signed(rs1_q) >>> shamt) : (rs1_q >> shamt);
      default: alu = '0;
    endcase
  end

  // Pipeline registers: latch word on accept, operands in DECODE, result in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      rs1_q   <= '0;
      imm_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) instr_q <= instr;
        S_DECODE: begin
          rs1_q <= rs1_val;
          imm_q <= {{(XLEN-12){dec_hi12[11]}}, dec_hi12};
          f3_q  <= dec_f3;
          rd_q  <= dec_rd;
          ill_q <= dec_ill;
        end
        S_EXEC: res_q <= alu;
        default: ;
      endcase
    end
  end

  // Register file writes: retiring instruction in WB, or debug preload while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q[0] <= '0;
      for (int i = 1; i < NREGS; i++) begin
        if (wb_we && rd_q == 5'(i))
          regs_q[i] <= res_q;
        else if (dbg_ok && dbg_addr == 5'(i))
          regs_q[i] <= dbg_wdata;
      end
    end
  end

endmodule

// File: tb/tb_riscv_opimm_exec.sv
// Bench for riscv_opimm_exec: a 32-bit/32-reg instance and a 64-bit/16-reg instance.
// Expected completions are queued at accept time and compared when done pulses.
// Register contents are checked through the debug read port against a bench-side model.
module tb_riscv_opimm_exec;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        in_valid_a, in_ready_a, done_a, illegal_a, dbg_we_a;
  logic [31:0] instr_a, wb_data_a, dbg_wdata_a, dbg_rdata_a;
  logic [4:0]  wb_rd_a, dbg_addr_a;

  logic        in_valid_b, in_ready_b, done_b, illegal_b, dbg_we_b;
  logic [31:0] instr_b;
  logic [63:0] wb_data_b, dbg_wdata_b, dbg_rdata_b;
  logic [4:0]  wb_rd_b, dbg_addr_b;

  riscv_opimm_exec #(.XLEN(32), .NREGS(32)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .instr(instr_a),
    .done(done_a), .illegal(illegal_a), .wb_rd(wb_rd_a), .wb_data(wb_data_a),
    .dbg_we(dbg_we_a), .dbg_addr(dbg_addr_a), .dbg_wdata(dbg_wdata_a), .dbg_rdata(dbg_rdata_a)
  );

  riscv_opimm_exec #(.XLEN(64), .NREGS(16)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .instr(instr_b),
    .done(done_b), .illegal(illegal_b), .wb_rd(wb_rd_b), .wb_data(wb_data_b),
    .dbg_we(dbg_we_b), .dbg_addr(dbg_addr_b), .dbg_wdata(dbg_wdata_b), .dbg_rdata(dbg_rdata_b)
  );

  typedef struct packed {
    logic        ill;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [63:0] model_a [32];
  logic [63:0] model_b [16];
  int          checks = 0;
  int          errors = 0;
  int          edges = 0;
  int          last_acc_a = 0;
  int          acc1;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] opc = 7'h13);
    return {imm, rs1, f3, rd, opc};
  endfunction

  // Completion monitors
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (done_a) begin
      if (q_a.size() == 0) chk("a_unexpected_done", 64'd1, 64'd0);
      else begin
        e = q_a.pop_front();
        chk("a_illegal", {63'd0, illegal_a}, {63'd0, e.ill});
        chk("a_wb_rd", {59'd0, wb_rd_a}, {59'd0, e.rd});
        chk("a_wb_data", {32'd0, wb_data_a}, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (done_b) begin
      if (q_b.size() == 0) chk("b_unexpected_done", 64'd1, 64'd0);
      else begin
        e = q_b.pop_front();
        chk("b_illegal", {63'd0, illegal_b}, {63'd0, e.ill});
        chk("b_wb_rd", {59'd0, wb_rd_b}, {59'd0, e.rd});
        chk("b_wb_data", wb_data_b, e.data);
      end
    end
  end

  task automatic issue_a(input logic [31:0] w, input logic ill, input logic [63:0] data,
                         input bit track = 1'b1, input bit dwe = 1'b0,
                         input logic [4:0] dad = 5'd0, input logic [63:0] dwd = 64'd0);
    int n = 0;
    exp_t e;
    @(negedge clk);
    in_valid_a = 1'b1;
    instr_a    = w;
    if (dwe) begin
      dbg_we_a = 1'b1; dbg_addr_a = dad; dbg_wdata_a = dwd[31:0];
      if (dad != 5'd0) model_a[dad] = {32'd0, dwd[31:0]};
    end
    while (!in_ready_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_a) begin
      chk("a_accept_timeout", 64'd0, 64'd1);
    end else if (track) begin
      e.ill = ill; e.rd = w[11:7]; e.data = data;
      q_a.push_back(e);
      if (!ill && w[11:7] != 5'd0) model_a[w[11:7]] = data;
    end
    @(posedge clk);
    #1;
    last_acc_a = edges;
    in_valid_a = 1'b0;
    dbg_we_a   = 1'b0;
  endtask

  task automatic issue_b(input logic [31:0] w, input logic ill, input logic [63:0] data);
    int n = 0;
    exp_t e;
    @(negedge clk);
    in_valid_b = 1'b1;
    instr_b    = w;
    while (!in_ready_b && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_b) begin
      chk("b_accept_timeout", 64'd0, 64'd1);
    end else begin
      e.ill = ill; e.rd = w[11:7]; e.data = data;
      q_b.push_back(e);
      if (!ill && w[11:7] != 5'd0 && w[11:7] < 5'd16) model_b[w[11:7][3:0]] = data;
    end
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (q_a.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q_a.size() != 0) begin
      chk("a_drain_timeout", 64'(q_a.size()), 64'd0);
      q_a.delete();
    end
  endtask

  task automatic drain_b();
    int n = 0;
    while (q_b.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q_b.size() != 0) begin
      chk("b_drain_timeout", 64'(q_b.size()), 64'd0);
      q_b.delete();
    end
  endtask

  task automatic dbg_wr_a(input logic [4:0] a, input logic [31:0] d, input bit take);
    @(negedge clk);
    dbg_we_a = 1'b1; dbg_addr_a = a; dbg_wdata_a = d;
    @(posedge clk);
    #1;
    dbg_we_a = 1'b0;
    if (take) model_a[a] = {32'd0, d};
  endtask

  task automatic dbg_wr_b(input logic [4:0] a, input logic [63:0] d, input bit take);
    @(negedge clk);
    dbg_we_b = 1'b1; dbg_addr_b = a; dbg_wdata_b = d;
    @(posedge clk);
    #1;
    dbg_we_b = 1'b0;
    if (take) model_b[a[3:0]] = d;
  endtask

  task automatic chk_reg_a(input logic [4:0] idx);
    @(negedge clk);
    dbg_addr_a = idx;
    #1;
    chk($sformatf("a_x%0d", idx), {32'd0, dbg_rdata_a}, model_a[idx]);
  endtask

  task automatic chk_reg_b(input logic [3:0] idx);
    @(negedge clk);
    dbg_addr_b = {1'b0, idx};
    #1;
    chk($sformatf("b_x%0d", idx), dbg_rdata_b, model_b[idx]);
  endtask

  initial begin
    rst = 1'b1;
    in_valid_a = 1'b0; instr_a = '0; dbg_we_a = 1'b0; dbg_addr_a = '0; dbg_wdata_a = '0;
    in_valid_b = 1'b0; instr_b = '0; dbg_we_b = 1'b0; dbg_addr_b = '0; dbg_wdata_b = '0;
    for (int i = 0; i < 32; i++) model_a[i] = '0;
    for (int i = 0; i < 16; i++) model_b[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("a_rst_in_ready", {63'd0, in_ready_a}, 64'd1);
    chk("a_rst_done", {63'd0, done_a}, 64'd0);
    chk("a_rst_illegal", {63'd0, illegal_a}, 64'd0);
    chk("a_rst_wb_rd", {59'd0, wb_rd_a}, 64'd0);
    chk("a_rst_wb_data", {32'd0, wb_data_a}, 64'd0);
    chk("b_rst_in_ready", {63'd0, in_ready_b}, 64'd1);
    chk_reg_a(5'd5);

    // Preloads
    dbg_wr_a(5'd4, 32'd0, 1'b1);
    dbg_wr_a(5'd5, 32'd1, 1'b1);
    dbg_wr_a(5'd1, 32'hffffff80, 1'b1);
    dbg_wr_a(5'd17, 32'h1234, 1'b1);

    // ori x0,x4,0xfe: completes with data, x0 untouched
    issue_a(enc(12'h0fe, 5'd4, 3'd6, 5'd0), 1'b0, 64'hfe);
    drain_a();
    chk_reg_a(5'd0);

    // Dependent pair, second accepted exactly 4 edges after the first
    issue_a(enc(12'h000, 5'd5, 3'd6, 5'd4), 1'b0, 64'h1);
    acc1 = last_acc_a;
    issue_a(enc(12'h0fe, 5'd4, 3'd6, 5'd4), 1'b0, 64'hff);
    chk("a_b2b_gap", 64'(last_acc_a - acc1), 64'd4);
    drain_a();
    chk_reg_a(5'd4);

    // Arithmetic, compare, logic and shift ops on x1 = 0xffffff80
    issue_a(enc(12'h404, 5'd1, 3'd5, 5'd2),  1'b0, 64'hfffffff8); // srai 4
    issue_a(enc(12'h004, 5'd1, 3'd5, 5'd3),  1'b0, 64'h0ffffff8); // srli 4
    issue_a(enc(12'hfff, 5'd0, 3'd3, 5'd6),  1'b0, 64'h1);        // sltiu x0,-1
    issue_a(enc(12'h000, 5'd1, 3'd2, 5'd7),  1'b0, 64'h1);        // slti x1,0
    issue_a(enc(12'h080, 5'd1, 3'd0, 5'd8),  1'b0, 64'h0);        // addi wrap
    issue_a(enc(12'hfff, 5'd1, 3'd4, 5'd9),  1'b0, 64'h7f);       // xori -1
    issue_a(enc(12'h0f0, 5'd1, 3'd7, 5'd10), 1'b0, 64'h80);       // andi
    issue_a(enc(12'h01f, 5'd5, 3'd1, 5'd11), 1'b0, 64'h80000000); // slli 31
    issue_a(enc(12'hfff, 5'd5, 3'd2, 5'd12), 1'b0, 64'h0);        // slti 1 < -1
    issue_a(enc(12'h002, 5'd5, 3'd3, 5'd13), 1'b0, 64'h1);        // sltiu 1 < 2
    issue_a(enc(12'h41f, 5'd1, 3'd5, 5'd16), 1'b0, 64'hffffffff); // srai 31
    drain_a();
    chk_reg_a(5'd2);
    chk_reg_a(5'd3);
    chk_reg_a(5'd8);
    chk_reg_a(5'd11);
    chk_reg_a(5'd16);

    // Illegal forms: no write, data reads zero
    issue_a(enc(12'h41f, 5'd1, 3'd1, 5'd14), 1'b1, 64'h0);         // slli with instr[30]
    issue_a(enc(12'h024, 5'd1, 3'd5, 5'd15), 1'b1, 64'h0);         // srli with instr[25]
    issue_a(enc(12'h000, 5'd1, 3'd0, 5'd17, 7'h33), 1'b1, 64'h0);  // wrong opcode
    drain_a();
    chk_reg_a(5'd14);
    chk_reg_a(5'd15);
    chk_reg_a(5'd17);

    // Debug write in the handshake cycle is seen by the rs1 read
    issue_a(enc(12'h001, 5'd21, 3'd0, 5'd22), 1'b0, 64'h11, 1'b1, 1'b1, 5'd21, 64'h10);
    drain_a();
    chk_reg_a(5'd22);

    // Debug writes while busy or to x0 are dropped
    issue_a(enc(12'h000, 5'd0, 3'd0, 5'd23), 1'b0, 64'h0);
    dbg_wr_a(5'd20, 32'h55, 1'b0);
    drain_a();
    chk_reg_a(5'd20);
    dbg_wr_a(5'd0, 32'h5, 1'b0);
    chk_reg_a(5'd0);

    // 64-bit / 16-register instance
    dbg_wr_b(5'd1, 64'd1, 1'b1);
    dbg_wr_b(5'd3, 64'h8000_0000_0000_0000, 1'b1);
    issue_b(enc(12'h03f, 5'd1, 3'd1, 5'd2), 1'b0, 64'h8000_0000_0000_0000); // slli 63
    issue_b(enc(12'h83f, 5'd1, 3'd1, 5'd6), 1'b1, 64'h0);                   // slli, instr[31]
    issue_b(enc(12'h43f, 5'd3, 3'd5, 5'd4), 1'b0, 64'hffff_ffff_ffff_ffff); // srai 63
    issue_b(enc(12'hfff, 5'd0, 3'd0, 5'd5), 1'b0, 64'hffff_ffff_ffff_ffff); // addi -1
    issue_b(enc(12'h020, 5'd1, 3'd1, 5'd8), 1'b0, 64'h0000_0001_0000_0000); // slli 32
    issue_b(enc(12'h005, 5'd1, 3'd0, 5'd20), 1'b1, 64'h0);                  // rd >= NREGS
    issue_b(enc(12'h001, 5'd18, 3'd0, 5'd7), 1'b1, 64'h0);                  // rs1 >= NREGS
    drain_b();
    chk_reg_b(4'd2);
    chk_reg_b(4'd4);
    chk_reg_b(4'd5);
    chk_reg_b(4'd6);
    chk_reg_b(4'd7);
    chk_reg_b(4'd8);
    dbg_wr_b(5'd20, 64'd5, 1'b0);
    @(negedge clk);
    dbg_addr_b = 5'd20;
    #1;
    chk("b_dbg_out_of_range", dbg_rdata_b, 64'd0);

    // Reset while in EXEC aborts the instruction
    issue_a(enc(12'h005, 5'd0, 3'd0, 5'd9), 1'b0, 64'h5, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model_a[i] = '0;
    for (int i = 0; i < 16; i++) model_b[i] = '0;
    chk("a_post_rst_in_ready", {63'd0, in_ready_a}, 64'd1);
    repeat (6) @(negedge clk);
    chk_reg_a(5'd9);
    chk_reg_a(5'd4);
    chk_reg_b(4'd2);
    issue_a(enc(12'h005, 5'd0, 3'd0, 5'd9), 1'b0, 64'h5);
    drain_a();
    chk_reg_a(5'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
